data_memory_pipelined: RTL and testbench

Parametrised successor to the CPU's single-word data memory. It adds:
- a request/ready handshake;
- byte-lane write enables;
- a configurable registered read latency;
- out-of-range and illegal-request error reporting;
- a hardware zero-fill after reset.

It sits between the datapath's load/store stage and on-chip RAM, and is the default data store for the 16-bit core and its wider variants.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_read_pipe.sv | 48 ++++
 rtl/data_memory_pipelined.sv | 124 ++++++++++++
 tb/tb_data_memory_pipelined.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the pipelined data memory.
// Holds the FSM encoding, the error-cause codes and the lane/index width derivations.
package dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_BOTH    = 2'd2,
        ERR_NONE_OP = 2'd3
    } err_t;

    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_read_pipe.sv
// Fixed-depth shift register carrying read-valid, error flag and read data; LATENCY cycles, no stall.
// Data stages load only alongside a valid, so the output data holds its last returned value.
module dmem_read_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_vld,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  out_vld,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_dat
);

    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    err_q;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            err_q[0] <= in_err;
            if (in_vld) begin
                dat_q[0] <= in_dat;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_vld = vld_q[LATENCY-1];
    assign out_err = err_q[LATENCY-1];
    assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/data_memory_pipelined.sv
// Word RAM with byte-lane writes, zero-fill after reset and fault reporting; reads return READ_LATENCY cycles after accept.
// ReqReady is low only while the zero-fill runs; once ready, every request is accepted and nothing stalls.
module data_memory_pipelined
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      ReqValid,
    output logic                      ReqReady,
    input  logic                      MemWrite,
    input  logic                      MemRead,
    input  logic [ADDR_WIDTH-1:0]     Address,
    input  logic [DATA_WIDTH-1:0]     WriteData,
    input  logic [DATA_WIDTH/8-1:0]   ByteEnable,
    output logic [DATA_WIDTH-1:0]     ReadData,
    output logic                      ReadValid,
    output logic                      AccessError
);

    localparam int BYTES     = bytes_of(DATA_WIDTH);
    localparam int LANE_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W     = index_width(DEPTH);

    state_t                state;
    state_t                state_nxt;
    logic                  clr_we;
    logic [IDX_W-1:0]      clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      word_idx;
    err_t                  err_cause;
    logic                  acc;
    logic                  req_err;
    logic                  wr_acc;
    logic                  pipe_vld;
    logic                  pipe_err;
    logic [DATA_WIDTH-1:0] pipe_dat;

    assign word_addr = Address >> LANE_BITS;
    assign word_idx  = word_addr[IDX_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clr_we) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ReqReady  = 1'b0;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                ReqReady = 1'b1;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    // Opcode faults take priority over the range check so the cause reflects the malformed request.
    always_comb begin
        err_cause = ERR_OK;
        if (MemWrite && MemRead) begin
            err_cause = ERR_BOTH;
        end else if (!MemWrite && !MemRead) begin
            err_cause = ERR_NONE_OP;
        end else if (64'(word_addr) >= 64'(DEPTH)) begin
            err_cause = ERR_RANGE;
        end
    end

    assign acc     = ReqValid && ReqReady;
    assign req_err = (err_cause != ERR_OK);
    assign wr_acc  = acc && MemWrite && !req_err;

    // Any request carrying MemRead gets a ReadValid so a waiting load stage always sees a response.
    assign pipe_vld = acc && MemRead;
    assign pipe_err = acc && req_err;
    assign pipe_dat = req_err ? '0 : mem[word_idx];

    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < BYTES; b++) begin
                if (ByteEnable[b]) begin
                    mem[word_idx][8*b +: 8] <= WriteData[8*b +: 8];
                end
            end
        end
    end

    dmem_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_read_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .in_vld  (pipe_vld),
        .in_err  (pipe_err),
        .in_dat  (pipe_dat),
        .out_vld (ReadValid),
        .out_err (AccessError),
        .out_dat (ReadData)
    );

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Drives latency-1 and latency-3 instances with identical requests; a scoreboard of expected responses
// from an array model is consumed by a negedge monitor per instance.
module tb_data_memory_pipelined;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic        req_valid  = 1'b0;
    logic        mem_write  = 1'b0;
    logic        mem_read   = 1'b0;
    logic [15:0] address    = 16'h0;
    logic [15:0] write_data = 16'h0;
    logic [1:0]  byte_en    = 2'b00;

    logic        rdy1, rv1, ae1, rdy3, rv3, ae3;
    logic [15:0] rd1, rd3;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int          acc;
        bit          rv;
        bit          ae;
        logic [15:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    int          ptr [2];
    logic [15:0] last_rd [2];
    logic [15:0] mdl [256];

    data_memory_pipelined #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .READ_LATENCY(1)
    ) dut1 (
        .clock(clk), .reset_n(reset_n), .ReqValid(req_valid), .ReqReady(rdy1),
        .MemWrite(mem_write), .MemRead(mem_read), .Address(address),
        .WriteData(write_data), .ByteEnable(byte_en), .ReadData(rd1),
        .ReadValid(rv1), .AccessError(ae1)
    );

    data_memory_pipelined #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .READ_LATENCY(3)
    ) dut3 (
        .clock(clk), .reset_n(reset_n), .ReqValid(req_valid), .ReqReady(rdy3),
        .MemWrite(mem_write), .MemRead(mem_read), .Address(address),
        .WriteData(write_data), .ByteEnable(byte_en), .ReadData(rd3),
        .ReadValid(rv3), .AccessError(ae3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Memory content after a completed zero-fill; anything still in flight is lost.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0;
        ptr[0] = exp_q.size();
        ptr[1] = exp_q.size();
    endtask

    task automatic do_req(input bit w, input bit r, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] be, output int waited);
        int   word;
        bit   err;
        exp_t e;
        req_valid  = 1'b1;
        mem_write  = w;
        mem_read   = r;
        address    = a;
        write_data = d;
        byte_en    = be;
        waited = 0;
        while (!rdy1 && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!rdy1) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: ReqReady still 0 after %0d cycles, required 1", waited);
        end else begin
            word = int'(a) >> 1;
            err  = (w && r) || (!w && !r) || (word >= 256);
            if (r || err) begin
                e.acc = cyc;
                e.rv  = r;
                e.ae  = err;
                e.dat = err ? 16'h0 : mdl[word];
                exp_q.push_back(e);
            end
            if (w && !err) begin
                for (int b = 0; b < 2; b++)
                    if (be[b]) mdl[word][8*b +: 8] = d[8*b +: 8];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic req(input bit w, input bit r, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] be);
        int waited;
        do_req(w, r, a, d, be, waited);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(posedge clk); #1;
    endtask

    logic        m_rv, m_ae;
    logic [15:0] m_rd;
    int          m_lat;
    exp_t        m_e;

    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 2; k++) begin
                m_rv  = (k == 0) ? rv1 : rv3;
                m_ae  = (k == 0) ? ae1 : ae3;
                m_rd  = (k == 0) ? rd1 : rd3;
                m_lat = (k == 0) ? 1 : 3;
                if (reset_n) begin
                    if (m_rv || m_ae) begin
                        tests++;
                        if (ptr[k] >= exp_q.size()) begin
                            fails++;
                            $display("FAIL lat%0d_unexpected: cycle %0d got rv=%0b ae=%0b data=%h, required no response",
                                     m_lat, cyc, m_rv, m_ae, m_rd);
                        end else begin
                            m_e = exp_q[ptr[k]];
                            ptr[k]++;
                            if (cyc != m_e.acc + m_lat || m_rv !== m_e.rv || m_ae !== m_e.ae ||
                                (m_e.rv ? (m_rd !== m_e.dat) : (m_rd !== last_rd[k]))) begin
                                fails++;
                                $display("FAIL lat%0d_resp: got cycle %0d rv=%0b ae=%0b data=%h, required cycle %0d rv=%0b ae=%0b data=%h",
                                         m_lat, cyc, m_rv, m_ae, m_rd, m_e.acc + m_lat, m_e.rv, m_e.ae,
                                         m_e.rv ? m_e.dat : last_rd[k]);
                            end
                        end
                    end else begin
                        if (ptr[k] < exp_q.size() && cyc >= exp_q[ptr[k]].acc + m_lat) begin
                            tests++;
                            fails++;
                            $display("FAIL lat%0d_missing: no response at cycle %0d, required one at cycle %0d",
                                     m_lat, cyc, exp_q[ptr[k]].acc + m_lat);
                            ptr[k]++;
                        end
                        tests++;
                        if (m_rd !== last_rd[k]) begin
                            fails++;
                            $display("FAIL lat%0d_hold: ReadData %h while idle, required held %h",
                                     m_lat, m_rd, last_rd[k]);
                        end
                    end
                end
                last_rd[k] = m_rd;
            end
        end
    end

    initial begin
        int waited;
        int r;
        logic [15:0] a;
        ptr[0] = 0;
        ptr[1] = 0;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;

        #1 reset_n = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_l1", rdy1, 0);
        chk("rst_ready_l3", rdy3, 0);
        chk("rst_valid_l1", rv1, 0);
        chk("rst_valid_l3", rv3, 0);
        chk("rst_error_l1", ae1, 0);
        chk("rst_error_l3", ae3, 0);
        chk("rst_data_l1", rd1, 0);
        chk("rst_data_l3", rd3, 0);

        // Read held through the zero-fill: accepted in the first ready cycle.
        model_reset();
        reset_n = 1'b1;
        do_req(0, 1, 16'd0, 16'h0, 2'b00, waited);
        chk("clear_cycles", waited, 256);
        chk("ready_l3", rdy3, 1);
        req(0, 1, 16'd200, 16'h0, 2'b00);
        req(0, 1, 16'd510, 16'h0, 2'b00);
        idle();

        req(1, 0, 16'd12, 16'h0012, 2'b11);
        req(0, 1, 16'd12, 16'h0, 2'b00);
        idle();

        req(1, 0, 16'd12, 16'hABCD, 2'b11);
        req(1, 0, 16'd12, 16'h1234, 2'b01);
        req(0, 1, 16'd12, 16'h0, 2'b00);
        idle();

        req(1, 0, 16'd0, 16'd1, 2'b11);
        req(1, 0, 16'd2, 16'd2, 2'b11);
        req(1, 0, 16'd4, 16'd3, 2'b11);
        req(0, 1, 16'd0, 16'h0, 2'b00);
        req(0, 1, 16'd2, 16'h0, 2'b00);
        req(0, 1, 16'd4, 16'h0, 2'b00);
        idle();

        req(0, 1, 16'h0400, 16'h0, 2'b00);
        req(1, 1, 16'd12, 16'hFFFF, 2'b11);
        req(0, 1, 16'd12, 16'h0, 2'b00);
        req(0, 0, 16'd12, 16'h0, 2'b11);
        req(1, 0, 16'd13, 16'h5555, 2'b00);
        req(1, 0, 16'h0400, 16'h7777, 2'b11);
        req(0, 1, 16'd13, 16'h0, 2'b00);
        repeat (4) idle();

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            a = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(512, 65535))
                                             : 16'($urandom_range(0, 63));
            if (r < 5)       idle();
            else if (r < 50) req(1, 0, a, 16'($urandom), 2'($urandom_range(0, 3)));
            else if (r < 88) req(0, 1, a, 16'h0, 2'b00);
            else if (r < 94) req(1, 1, a, 16'($urandom), 2'b11);
            else             req(0, 0, a, 16'h0, 2'b00);
        end
        repeat (5) idle();

        // Three reads in flight, then a one-cycle reset.
        req(1, 0, 16'd6, 16'hBEEF, 2'b11);
        req(0, 1, 16'd0, 16'h0, 2'b00);
        req(0, 1, 16'd2, 16'h0, 2'b00);
        req(0, 1, 16'd4, 16'h0, 2'b00);
        req_valid = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        reset_n   = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        do_req(0, 1, 16'd6, 16'h0, 2'b00, waited);
        chk("clear_cycles_again", waited, 256);
        req(0, 1, 16'd0, 16'h0, 2'b00);
        req(0, 1, 16'd510, 16'h0, 2'b00);
        repeat (8) idle();

        chk("drain_l1", ptr[0], exp_q.size());
        chk("drain_l3", ptr[1], exp_q.size());
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
